// File: rtl/ct_spsram_param_init_if.sv
// Access bus of the self-initialising single-port SRAM.
// The master drives the address/command/data; the slave returns read data and init status.
interface ct_spsram_param_init_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 23
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic                  INIT_REQ;
  logic [DATA_WIDTH-1:0] Q;
  logic                  INIT_DONE;

  modport master (
    output A, CEN, GWEN, WEN, D, INIT_REQ,
    input  Q, INIT_DONE
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D, INIT_REQ,
    output Q, INIT_DONE
  );
endinterface

// File: rtl/ct_spsram_param_init.sv
// Single-port SRAM that sweeps INIT_VAL into every word after reset or on request,
// then serves bit-masked writes and reads with an optional output register stage.
module ct_spsram_param_init #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 23,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic                  CLK,
  input logic                  RST,
  ct_spsram_param_init_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [DATA_WIDTH-1:0] wr_mask_s;

  // Next state plus the single array write port: the sweep owns it in INIT, the bus in READY.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    wr_addr_s = bus.A;
    wr_data_s = bus.D;
    wr_mask_s = ~bus.WEN;
    case (state_q)
      ST_INIT: begin
        wr_en_s   = 1'b1;
        wr_addr_s = cnt_q;
        wr_data_s = INIT_VAL;
        wr_mask_s = '1;
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_READY: begin
        if (!bus.CEN) begin
          wr_en_s = !bus.GWEN;
          rd_en_s = bus.GWEN;
        end else begin
          wr_en_s = 1'b0;
          rd_en_s = 1'b0;
        end
        // The current access still completes; the sweep starts on the following edge.
        if (bus.INIT_REQ) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State, sweep counter and the registered ready flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  // Array contents survive reset; only the sweep restores them.
  always_ff @(posedge CLK) begin
    if (wr_en_s && !RST) begin
      mem_q[wr_addr_s] <= (mem_q[wr_addr_s] & ~wr_mask_s) | (wr_data_s & wr_mask_s);
    end
  end

  // First read stage holds its value until the next read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_q <= '0;
    end else if (rd_en_s) begin
      rd_data_q <= mem_q[bus.A];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  rd_vld_q;
      logic [DATA_WIDTH-1:0] q_q;

      // Output stage loads only behind a genuine read result.
      always_ff @(posedge CLK) begin
        if (RST) begin
          rd_vld_q <= 1'b0;
          q_q      <= '0;
        end else begin
          rd_vld_q <= rd_en_s;
          if (rd_vld_q) begin
            q_q <= rd_data_q;
          end
        end
      end

      assign bus.Q = q_q;
    end else begin : g_no_out_reg
      assign bus.Q = rd_data_q;
    end
  endgenerate

  assign bus.INIT_DONE = init_done_q;

endmodule
